call_frame_stack: RTL and testbench

- Hardware call-frame stack that sits directly downstream of the register management system (rms).
- Captures rms `fcOut` (15 saved 16-bit registers, 240 bits) on a call and returns it on `fcIn` on a return.
- Pulses the rms `restore` strobe one cycle after a pop, so rms reloads the frame.
- Push and pop strobes come from the control unit, aligned with call/return instructions.

---
 rtl/baej_pkg.sv | 13 +
 rtl/frame_ram.sv | 31 +++
 rtl/call_frame_stack.sv | 117 +++++++++++
 tb/tb_call_frame_stack.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/baej_pkg.sv
// rtl/baej_pkg.sv - shared frame geometry for rms and the call-frame stack
package baej_pkg;

  localparam int REG_W          = 16;
  localparam int NUM_SAVED_REGS = 15;
  localparam int FRAME_W        = REG_W * NUM_SAVED_REGS;

  // Bit offset of saved register idx inside a frame; slot 0 sits at the LSBs.
  function automatic int reg_lo(input int idx);
    return idx * REG_W;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// rtl/frame_ram.sv - DEPTH x WIDTH frame store, sync write, sync read-before-write
module frame_ram #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 240,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Non-blocking update gives old contents on a same-address read and write.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/call_frame_stack.sv
// rtl/call_frame_stack.sv - call-frame stack between rms fcOut and fcIn
module call_frame_stack #(
  parameter int DEPTH   = 8,
  parameter int FRAME_W = baej_pkg::FRAME_W,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               clear_err,
  output logic [FRAME_W-1:0] frame_out,
  output logic               restore_out,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);
  import baej_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               restore_q;
  logic               rd_valid_q;
  logic               do_write, do_read;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [FRAME_W-1:0] rd_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    do_write    = 1'b0;
    do_read     = 1'b0;
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    rd_addr = ADDR_W'(count_q - CNT_W'(1));
    // A swap overwrites the current top; otherwise the write lands just above it.
    wr_addr = (pop && !empty) ? rd_addr : ADDR_W'(count_q);
    case ({push, pop})
      2'b10: begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          do_write = 1'b1;
          count_d  = count_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          do_read = 1'b1;
          count_d = count_q - CNT_W'(1);
        end
      end
      2'b11: begin
        do_write = 1'b1;
        if (empty) begin
          count_d     = CNT_W'(1);
          underflow_d = 1'b1;
        end else begin
          do_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      restore_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      restore_q   <= do_read;
      rd_valid_q  <= rd_valid_q | do_read;
    end
  end

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W),
    .ADDR_W(ADDR_W)
  ) u_frame_ram (
    .clk_i    (clk),
    .wr_en_i  (do_write),
    .wr_addr_i(wr_addr),
    .wr_data_i(frame_in),
    .rd_en_i  (do_read),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  // The RAM has no reset, so frame_out reads as zero until the first real pop.
  assign frame_out   = rd_valid_q ? rd_data : '0;
  assign restore_out = restore_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_call_frame_stack.sv
// tb/tb_call_frame_stack.sv - directed vector bench for call_frame_stack
module tb_call_frame_stack;
  import baej_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               push, pop, clear_err;
  logic [FRAME_W-1:0] frame_in;
  logic [FRAME_W-1:0] frame_out;
  logic               restore_out;
  logic [CNT_W-1:0]   count;
  logic               full, empty, overflow, underflow;

  always #5 clk = ~clk;

  call_frame_stack #(
    .DEPTH  (DEPTH),
    .FRAME_W(FRAME_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .frame_in   (frame_in),
    .clear_err  (clear_err),
    .frame_out  (frame_out),
    .restore_out(restore_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [15:0] in_b;
    int          cnt;
    logic        rst;
    logic [15:0] out_b;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  // Register k of a frame built from base b holds b+k; base 0 stands for the all-zero frame.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [15:0] b);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_SAVED_REGS; k++) begin
      f[reg_lo(k) +: REG_W] = b + 16'(k);
    end
    return (b == 16'h0) ? '0 : f;
  endfunction

  task automatic add(input logic p, input logic q, input logic c, input logic [15:0] ib,
                     input int cn, input logic r, input logic [15:0] ob,
                     input logic ov, input logic un);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.in_b = ib; v.cnt = cn;
    v.rst = r; v.out_b = ob; v.ovf = ov; v.unf = un;
    vq.push_back(v);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FRAME_W-1:0] act,
                             input logic [FRAME_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int cn, input logic r,
                             input logic [FRAME_W-1:0] fr, input logic ov, input logic un);
    check_val({tag, ".count"}, int'(count), cn);
    check_val({tag, ".restore"}, int'(restore_out), int'(r));
    check_frame({tag, ".frame"}, frame_out, fr);
    check_val({tag, ".overflow"}, int'(overflow), int'(ov));
    check_val({tag, ".underflow"}, int'(underflow), int'(un));
    check_val({tag, ".full"}, int'(full), (cn == DEPTH) ? 1 : 0);
    check_val({tag, ".empty"}, int'(empty), (cn == 0) ? 1 : 0);
  endtask

  initial begin
    // single push then pop
    add(1, 0, 0, 16'h1000, 1, 0, 16'h0000, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 1, 16'h1000, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h1000, 0, 0);
    // fill, overflow, drain in LIFO order
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 16'(i), i, 0, 16'h1000, 0, 0);
    add(1, 0, 0, 16'h0009, 8, 0, 16'h1000, 1, 0);
    for (int i = 8; i >= 1; i--) add(0, 1, 0, 16'h0000, i - 1, 1, 16'(i), 1, 0);
    // underflow with clear in the same cycle (set wins), then clear alone
    add(0, 1, 1, 16'h0000, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0001, 0, 1);
    add(0, 0, 1, 16'h0000, 0, 0, 16'h0001, 0, 0);
    // swap returns the old top, following pop returns the swapped-in frame
    add(1, 0, 0, 16'h2000, 1, 0, 16'h0001, 0, 0);
    add(1, 1, 0, 16'h3000, 1, 1, 16'h2000, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 1, 16'h3000, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h3000, 0, 0);
    // push+pop while empty behaves as push plus underflow
    add(1, 1, 0, 16'h4000, 1, 0, 16'h3000, 0, 1);
    add(0, 1, 0, 16'h0000, 0, 1, 16'h4000, 0, 1);
    add(0, 0, 1, 16'h0000, 0, 0, 16'h4000, 0, 0);
    // swap while full, then overflow, then pop the swapped frame
    for (int i = 0; i < 8; i++) add(1, 0, 0, 16'h5000 + 16'(i * 16), i + 1, 0, 16'h4000, 0, 0);
    add(1, 1, 0, 16'h6000, 8, 1, 16'h5070, 0, 0);
    add(1, 0, 0, 16'h7000, 8, 0, 16'h5070, 1, 0);
    add(0, 1, 0, 16'h0000, 7, 1, 16'h6000, 1, 0);

    reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; frame_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vq[i]) begin
      push      = vq[i].push;
      pop       = vq[i].pop;
      clear_err = vq[i].clr;
      frame_in  = make_frame(vq[i].in_b);
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vq[i].cnt, vq[i].rst, make_frame(vq[i].out_b),
                  vq[i].ovf, vq[i].unf);
    end

    // async reset mid-cycle while a restore pulse is high
    push = 1'b0; pop = 1'b1; clear_err = 1'b0; frame_in = '0;
    @(posedge clk);
    #1;
    check_state("pre_reset", 6, 1'b1, make_frame(16'h5060), 1'b1, 1'b0);
    pop = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_state("mid_reset", 0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_reset", 0, 1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
